// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch request controller (BOOT/FETCH/STALL).
// Optional: define PC_MISALIGN_TRAP_EN to trap misaligned redirects to TRAP_VEC.
module pc_fetch_ctrl #(
  parameter int          N         = 32,
  parameter logic [N-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [N-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  output logic [N-1:0] adder_a,
  output logic [N-1:0] adder_b,
  input  logic [N-1:0] adder_sum,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_addr,
  output logic [N-1:0] pc,
  output logic [31:0]  instret,
  output logic         trap_pulse
);

  typedef enum logic [1:0] {BOOT, FETCH, STALL} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pc_nxt;
  logic [31:0]  instret_nxt;
  logic         trap_nxt;
  logic         hs;

  assign adder_a        = pc;
  assign adder_b        = N'(4);
  assign imem_addr      = pc;
  assign imem_req_valid = (state == FETCH);
  assign hs             = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_VEC;
      instret <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instret <= instret_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instret_nxt = instret;
    trap_nxt    = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH, STALL: begin
        // Redirect overrides everything, including a handshake in the same cycle.
        if (redirect_valid) begin
          state_nxt = FETCH;
`ifdef PC_MISALIGN_TRAP_EN
          if (redirect_target[1:0] != 2'b00) begin
            pc_nxt   = TRAP_VEC;
            trap_nxt = 1'b1;
          end else begin
            pc_nxt = redirect_target;
          end
`else
          pc_nxt = {redirect_target[N-1:2], 2'b00};
`endif
        end else if (state == FETCH) begin
          if (hs) begin
            pc_nxt      = adder_sum;
            instret_nxt = instret + 32'd1;
            if (stall) state_nxt = STALL;
          end
        end else if (!stall) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_pulse <= 1'b0;
    else        trap_pulse <= trap_nxt;
  end
`else
  logic unused_trap;
  assign unused_trap = ^{TRAP_VEC, redirect_target[1:0], trap_nxt};
  assign trap_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed test-plan scenarios plus
// randomized stall/ready/redirect traffic against an abstract fetch model.
module tb_pc_fetch_ctrl;
  localparam int          N  = 32;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic         clk = 1'b0, rst_n = 1'b1;
  logic         stall = 1'b0, redirect_valid = 1'b0, imem_req_ready = 1'b0;
  logic [N-1:0] redirect_target = '0;
  logic [N-1:0] adder_a, adder_b, adder_sum, imem_addr, pc;
  logic         imem_req_valid, trap_pulse;
  logic [31:0]  instret;

  int n_chk = 0, n_fail = 0;

  // Abstract model: where fetch is, how many fetches retired, whether held.
  logic [31:0] m_pc, m_cnt;
  bit          m_boot, m_held, m_trap;

  always #5 clk = ~clk;

  // Stand-in for the external adder.
  assign adder_sum = adder_a + adder_b;

  pc_fetch_ctrl #(.N(N), .RESET_VEC(RV), .TRAP_VEC(TV)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .pc(pc), .instret(instret), .trap_pulse(trap_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit trap_on();
`ifdef PC_MISALIGN_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = RV; m_cnt = 0; m_boot = 1; m_held = 0; m_trap = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, imem_req_valid}, 0);
    chk("rst_pc", pc, RV);
    chk("rst_instret", instret, 0);
    chk("rst_trap", {31'd0, trap_pulse}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: apply inputs, check outputs at negedge, advance model at posedge.
  task automatic cyc(input bit st, input bit rdy, input bit rv, input logic [31:0] rt);
    bit fetching;
    stall = st; imem_req_ready = rdy; redirect_valid = rv; redirect_target = rt;
    @(negedge clk);
    fetching = !m_boot && !m_held;
    chk("valid", {31'd0, imem_req_valid}, {31'd0, fetching});
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("adder_a", adder_a, m_pc);
    chk("instret", instret, m_cnt);
    chk("trap", {31'd0, trap_pulse}, {31'd0, m_trap});
    @(posedge clk);
    m_trap = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (rv) begin
      m_held = 0;
      if (trap_on() && rt[1:0] != 2'b00) begin
        m_pc = TV; m_trap = 1;
      end else begin
        m_pc = rt & 32'hFFFF_FFFC;
      end
    end else if (fetching && rdy) begin
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      m_held = st;
    end else if (m_held && !st) begin
      m_held = 0;
    end
    #1;
  endtask

  initial begin
    logic [31:0] tgt, cnt_snap;
    #2;
    do_reset();
    chk("adder_b", adder_b, 32'd4);

    // Boot then three back-to-back fetches.
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    chk("instret_3", instret, 32'd3);
    chk("pc_0xc", pc, 32'h0000_000C);

    // Held request at 0x10; stall ignored while unaccepted.
    cyc(0, 0, 1, 32'h10);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("addr_0x14", imem_addr, 32'h14);

    // Handshake with stall at 0x20.
    cyc(0, 0, 1, 32'h20);
    cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    chk("stall_pc", pc, 32'h24);
    chk("stall_valid", {31'd0, imem_req_valid}, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Redirect wins over a ready handshake; instret unchanged.
    cyc(0, 0, 1, 32'h40);
    cnt_snap = instret;
    cyc(0, 1, 1, 32'h200);
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_instret", instret, cnt_snap);
    cyc(0, 0, 0, 0);

    // Misaligned redirect.
    cyc(0, 0, 1, 32'h202);
    chk("misalign_pc", pc, trap_on() ? TV : 32'h200);
    chk("misalign_trap", {31'd0, trap_pulse}, {31'd0, trap_on()});
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // PC wrap.
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0);

    // Redirect together with stall while stalled.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 32'h300);
    cyc(1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = $urandom;
        default: tgt = $urandom & 32'h0000_0FFC;
      endcase
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) == 0, tgt);
    end

    // Async reset in the middle of a pending request.
    cyc(0, 0, 1, 32'h80);
    cyc(0, 0, 0, 0);
    chk("pre_rst_valid", {31'd0, imem_req_valid}, 1);
    #2;
    do_reset();
    repeat (4) cyc(0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-request controller for the single-cycle RISC-V core. It owns the architectural PC and drives operands into the existing `adder` (`address` = PC, `b` = 4), consuming its `pc_new` result as the sequential next PC. It issues one instruction-memory request per accepted PC over a valid/ready handshake and applies stalls and branch/jump redirects.

## Interface
- `N`, 32, datapath/address width
- `RESET_VEC`, 32'h0000_0000, PC loaded at reset
- `TRAP_VEC`, 32'h0000_0100, PC loaded on misaligned redirect (macro-enabled only)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold fetch after current handshake
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_target`  in  N  new PC for redirect
- `adder_a`  out  N  to `adder.address`; equals `pc`
- `adder_b`  out  N  to `adder.b`; constant 4
- `adder_sum`  in  N  from `adder.pc_new`
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  instruction memory accepts request
- `imem_addr`  out  N  fetch address; equals `pc`
- `pc`  out  N  current PC register
- `instret`  out  32  count of accepted fetches, wraps at 2^32
- `trap_pulse`  out  1  one-cycle misaligned-redirect flag

## Operation
- States: BOOT, FETCH, STALL.
- Reset (async, `rst_n`=0): state BOOT, `pc`=RESET_VEC, `instret`=0, `imem_req_valid`=0, `trap_pulse`=0.
- BOOT: `imem_req_valid`=0; next cycle → FETCH unconditionally; redirect ignored.
- FETCH: `imem_req_valid`=1, `imem_addr`=`pc`. Handshake = valid && ready.
  - Handshake, no redirect: `pc`<=`adder_sum`, `instret`++; `stall`=1 → STALL, else stay FETCH.
  - No handshake: `pc`, `imem_addr` held stable; `stall` ignored until handshake completes.
- STALL: `imem_req_valid`=0; `stall`=0 → FETCH (same `pc`).
- Redirect (FETCH or STALL) has highest priority: `pc`<=`redirect_target`, state → FETCH, pending request withdrawn (only permitted withdrawal), `instret` not incremented even if ready=1 that cycle.
- Arithmetic: N-bit modulo; `pc`=0xFFFF_FFFC +4 → 0x0000_0000, no flag.
- `instret` 32-bit wrap: 0xFFFF_FFFF → 0.
- Redirect and stall same cycle: redirect wins, state FETCH; stall re-evaluated on next handshake.

## Timing
- `pc` registered; `imem_addr`, `adder_a` combinational from `pc`; `adder_b` tied 4.
- `adder_sum` sampled at the handshake edge; adder combinational, settles within cycle.
- Throughput: ready held high, no stall → one fetch per cycle, addresses RESET_VEC, +4, +8 on consecutive cycles.
- Redirect latency: target on `imem_addr` the cycle after `redirect_valid` is sampled.
- First request: cycle after reset release (one BOOT cycle).
- `trap_pulse` high exactly one cycle, the cycle after the offending redirect.

## Configuration
- `PC_MISALIGN_TRAP_EN`:
  - Defined: redirect with `redirect_target[1:0]`≠0 loads `pc`=TRAP_VEC, asserts `trap_pulse`, state FETCH.
  - Undefined: `redirect_target[1:0]` forced to 0 before loading; `trap_pulse` tied 0; TRAP_VEC unused.

## Test plan
- Reset with RESET_VEC=0, ready=1 for 3 cycles after BOOT → `imem_addr` 0x0, 0x4, 0x8; `instret`=3.
- FETCH at pc=0x10, ready=0 for 4 cycles → `imem_addr`=0x10 and valid=1 throughout; ready=1 → next addr 0x14.
- Handshake at 0x20 with stall=1 for 3 cycles → valid=0 during STALL, pc=0x24; stall=0 → valid=1, addr 0x24.
- Redirect 0x200 while request pending at 0x40 with ready=1 → next addr 0x200, `instret` unchanged.
- Redirect 0x202: macro defined → pc=0x100, `trap_pulse` 1 cycle; undefined → pc=0x200, `trap_pulse`=0.
- Redirect 0xFFFF_FFFC then handshake → next addr 0x0000_0000; assert `rst_n`=0 mid-request → valid=0, pc=RESET_VEC immediately.
